// File: rtl/alu_4bit.sv
`default_nettype none
// ============================================================================
// alu_4bit : registered D = A + Y + Cin, Y selected from {B, ~B, 0, ones}
// Rev 1.0
// ============================================================================
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] D,
  output logic             Cout,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid
);

  localparam logic [1:0] c_sel_b    = 2'b00;
  localparam logic [1:0] c_sel_nb   = 2'b01;
  localparam logic [1:0] c_sel_zero = 2'b10;

  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_d;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;
  logic             r_valid;

  always_comb begin
    w_y = {WIDTH{1'b1}};
    case (sel)
      c_sel_b:    w_y = B;
      c_sel_nb:   w_y = ~B;
      c_sel_zero: w_y = '0;
      default:    w_y = {WIDTH{1'b1}};
    endcase
  end

  // Extend to WIDTH+1 bits so the top bit is the carry out of the MSB.
  assign w_sum  = {1'b0, A} + {1'b0, w_y} + {{WIDTH{1'b0}}, Cin};
  assign w_ovf  = (A[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  assign w_zero = (w_sum[WIDTH-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d     <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_d    <= w_sum[WIDTH-1:0];
        r_cout <= w_sum[WIDTH];
        r_zero <= w_zero;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign D         = r_d;
  assign Cout      = r_cout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_4bit.sv
`default_nettype none
// ============================================================================
// tb_alu_4bit : directed-vector bench for alu_4bit
// Rev 1.0
// ============================================================================
module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] sel;
  logic       Cin;
  logic       in_valid;
  logic [3:0] D;
  logic       Cout;
  logic       zero;
  logic       ovf;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  alu_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel), .Cin(Cin),
    .in_valid(in_valid), .D(D), .Cout(Cout), .zero(zero), .ovf(ovf),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ed, input logic ec,
                           input logic ez, input logic eo, input logic ev);
    check({tag, ".D"},         {4'b0, D},         {4'b0, ed});
    check({tag, ".Cout"},      {7'b0, Cout},      {7'b0, ec});
    check({tag, ".zero"},      {7'b0, zero},      {7'b0, ez});
    check({tag, ".ovf"},       {7'b0, ovf},       {7'b0, eo});
    check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, ev});
  endtask

  // Drive operands just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                      input logic c, input logic v);
    A = a; B = b; sel = s; Cin = c; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; sel = '0; Cin = 1'b0; in_valid = 1'b0;
    #3;
    check_out("reset", 4'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(4'b0110, 4'b0000, 2'b00, 1'b0, 1'b1);
    check_out("add_a6_b0", 4'b0110, 0, 0, 0, 1);
    step(4'b0011, 4'b0101, 2'b00, 1'b1, 1'b1);
    check_out("adc_3_5", 4'b1001, 0, 0, 1, 1);
    step(4'b0011, 4'b0101, 2'b00, 1'b0, 1'b1);
    check_out("add_3_5", 4'b1000, 0, 0, 1, 1);
    step(4'b0110, 4'b0011, 2'b01, 1'b1, 1'b1);
    check_out("sub_6_3", 4'b0011, 1, 0, 0, 1);
    step(4'b0110, 4'b0011, 2'b01, 1'b0, 1'b1);
    check_out("addnb_6_3", 4'b0010, 1, 0, 0, 1);
    step(4'b0110, 4'b0000, 2'b11, 1'b0, 1'b1);
    check_out("dec_6", 4'b0101, 1, 0, 0, 1);
    step(4'b0110, 4'b0000, 2'b11, 1'b1, 1'b1);
    check_out("xfer1_6", 4'b0110, 1, 0, 0, 1);
    step(4'b1111, 4'b0000, 2'b10, 1'b1, 1'b1);
    check_out("inc_f", 4'b0000, 1, 1, 0, 1);

    // Idle cycles with changing operands must not disturb the held result.
    step(4'b0101, 4'b0101, 2'b00, 1'b0, 1'b0);
    check_out("hold1", 4'b0000, 1, 1, 0, 0);
    step(4'b1010, 4'b0001, 2'b01, 1'b1, 1'b0);
    check_out("hold2", 4'b0000, 1, 1, 0, 0);

    step(4'b0111, 4'b0001, 2'b00, 1'b0, 1'b1);
    check_out("b2b_1", 4'b1000, 0, 0, 1, 1);
    step(4'b1000, 4'b0001, 2'b01, 1'b1, 1'b1);
    check_out("b2b_2", 4'b0111, 1, 0, 1, 1);
    step(4'b0010, 4'b0101, 2'b01, 1'b1, 1'b1);
    check_out("b2b_3_borrow", 4'b1101, 0, 0, 0, 1);
    step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    check_out("b2b_drop", 4'b1101, 0, 0, 0, 0);

    step(4'b0101, 4'b0010, 2'b00, 1'b0, 1'b1);
    check_out("pre_rst", 4'b0111, 0, 0, 0, 1);
    // Asynchronous reset between edges, with a valid operand pending.
    A = 4'b0011; B = 4'b0011; sel = 2'b00; Cin = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_out("rst_held", 4'h0, 0, 0, 0, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(4'b0011, 4'b0011, 2'b00, 1'b0, 1'b0);
    check_out("post_rst_idle", 4'h0, 0, 0, 0, 0);
    step(4'b0001, 4'b0001, 2'b00, 1'b0, 1'b1);
    check_out("post_rst_valid", 4'b0010, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
